cpu7_ecl_excp: RTL and testbench

- Exception/ERTN sequencer in the execution-control (ecl) unit, directly upstream of the CSR file.
- Watches the commit (WB) slot for interrupts, exceptions and ERTN.
- Produces the one-cycle `ecl_csr_except` / `ecl_csr_ertn` pulses and the ERA/ecode values the CSR file consumes.
- Flushes the pipeline, then holds a PC redirect (to EENTRY or ERA) under a valid/ready handshake with the fetch unit.

---
 rtl/cpu7_ecl_excp.sv | 148 ++++++++++++++
 tb/tb_cpu7_ecl_excp.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu7_ecl_excp.sv
// ---------------------------------------------------------------------------
// cpu7_ecl_excp
//
// Exception / ERTN sequencer of the execution-control unit. It sits between
// the commit (WB) slot and the CSR file.
//
// When the commit slot carries an interrupt, an exception or an ERTN, the
// sequencer:
//   1. kills the slot (interrupt/exception) or lets it retire (ERTN),
//   2. spends one cycle issuing a pipeline flush together with the CSR
//      side-effect pulse (except or ertn),
//   3. holds a PC redirect (EENTRY or ERA) towards fetch until fetch
//      accepts it with ifu_redirect_ready.
// While it is busy, commit-slot inputs are ignored and nothing is queued.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   wb_valid/pc/excp/     commit-slot instruction and its exception info
//   ecode/ertn
//   int_req, csr_crmd_ie  pending unmasked interrupt, global enable
//   csr_eentry, csr_era   exception entry and return address from CSR file
//   ifu_redirect_ready    fetch accepts the redirect
//   ecl_commit_en         commit-slot instruction may retire (combinational)
//   ecl_csr_except/ertn   one-cycle CSR side-effect pulses
//   ecl_csr_era/ecode     ERA / ESTAT.Ecode values, valid with ecl_csr_except
//   ecl_flush             one-cycle pipeline flush
//   ecl_redirect_valid/pc redirect request and target towards fetch
//   ecl_busy              sequencer is not idle
// ---------------------------------------------------------------------------
module cpu7_ecl_excp #(
    parameter int GRLEN   = 32,
    parameter int ECODE_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_valid,
    input  logic [GRLEN-1:0]   wb_pc,
    input  logic               wb_excp,
    input  logic [ECODE_W-1:0] wb_ecode,
    input  logic               wb_ertn,
    input  logic               int_req,
    input  logic               csr_crmd_ie,
    input  logic [GRLEN-1:0]   csr_eentry,
    input  logic [GRLEN-1:0]   csr_era,
    input  logic               ifu_redirect_ready,
    output logic               ecl_commit_en,
    output logic               ecl_csr_except,
    output logic               ecl_csr_ertn,
    output logic [GRLEN-1:0]   ecl_csr_era,
    output logic [ECODE_W-1:0] ecl_csr_ecode,
    output logic               ecl_flush,
    output logic               ecl_redirect_valid,
    output logic [GRLEN-1:0]   ecl_redirect_pc,
    output logic               ecl_busy
);

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_REDIR = 2'd2;

    // Kind of event being sequenced
    localparam logic [1:0] KIND_INT  = 2'd0;
    localparam logic [1:0] KIND_EXC  = 2'd1;
    localparam logic [1:0] KIND_ERTN = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         r_kind;
    logic [GRLEN-1:0]   r_era;
    logic [ECODE_W-1:0] r_ecode;
    logic [GRLEN-1:0]   r_redirect_pc;

    logic w_idle;
    logic w_take_int;
    logic w_take_exc;
    logic w_take_ertn;
    logic w_take_any;
    logic w_in_flush;

    // Events are only qualified in IDLE with a valid commit slot; this keeps
    // a stale int_req or wb_* from starting a sequence on an empty slot.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_take_int  = w_idle & wb_valid & int_req & csr_crmd_ie;
    assign w_take_exc  = w_idle & wb_valid & wb_excp;
    assign w_take_ertn = w_idle & wb_valid & wb_ertn;
    assign w_take_any  = w_take_int | w_take_exc | w_take_ertn;
    assign w_in_flush  = (r_state == ST_FLUSH);

    // ERTN retires normally; interrupted or excepting instructions are killed.
    assign ecl_commit_en = wb_valid & w_idle & ~w_take_int & ~w_take_exc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_kind        <= KIND_INT;
            r_era         <= '0;
            r_ecode       <= '0;
            r_redirect_pc <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take_any) begin
                        r_state <= ST_FLUSH;
                        r_era   <= wb_pc;
                        // Priority: interrupt over exception over ERTN.
                        // Ecode is left untouched for ERTN.
                        if (w_take_int) begin
                            r_kind  <= KIND_INT;
                            r_ecode <= '0;
                        end else if (w_take_exc) begin
                            r_kind  <= KIND_EXC;
                            r_ecode <= wb_ecode;
                        end else begin
                            r_kind  <= KIND_ERTN;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Target is captured in the flush cycle, before the CSR
                    // file acts on the except/ertn pulse, so a CSR write in
                    // this same cycle cannot leak into the redirect.
                    r_redirect_pc <= (r_kind == KIND_ERTN) ? csr_era : csr_eentry;
                    r_state       <= ST_REDIR;
                end
                ST_REDIR: begin
                    if (ifu_redirect_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pulses are decoded from the one-cycle FLUSH state, so a reset that
    // returns the state to IDLE also suppresses them.
    assign ecl_flush          = w_in_flush;
    assign ecl_csr_except     = w_in_flush & (r_kind != KIND_ERTN);
    assign ecl_csr_ertn       = w_in_flush & (r_kind == KIND_ERTN);
    assign ecl_redirect_valid = (r_state == ST_REDIR);
    assign ecl_busy           = ~w_idle;
    assign ecl_csr_era        = r_era;
    assign ecl_csr_ecode      = r_ecode;
    assign ecl_redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_cpu7_ecl_excp.sv
// ---------------------------------------------------------------------------
// tb_cpu7_ecl_excp
//
// Self-checking bench for cpu7_ecl_excp. Inputs change 1 ns after the rising
// edge, outputs are compared on the falling edge. The reference model tracks
// an outstanding event as a record (kind, era, ecode, target) plus its age in
// cycles since the event was accepted: age 1 is the flush cycle, age 2 and
// later is the redirect phase, which ends in the first cycle fetch is ready.
// ---------------------------------------------------------------------------
module tb_cpu7_ecl_excp;

    localparam int GRLEN   = 32;
    localparam int ECODE_W = 6;
    localparam int K_INT   = 0;
    localparam int K_EXC   = 1;
    localparam int K_ERTN  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               wb_valid;
    logic [GRLEN-1:0]   wb_pc;
    logic               wb_excp;
    logic [ECODE_W-1:0] wb_ecode;
    logic               wb_ertn;
    logic               int_req;
    logic               csr_crmd_ie;
    logic [GRLEN-1:0]   csr_eentry;
    logic [GRLEN-1:0]   csr_era;
    logic               ifu_redirect_ready;
    logic               ecl_commit_en;
    logic               ecl_csr_except;
    logic               ecl_csr_ertn;
    logic [GRLEN-1:0]   ecl_csr_era;
    logic [ECODE_W-1:0] ecl_csr_ecode;
    logic               ecl_flush;
    logic               ecl_redirect_valid;
    logic [GRLEN-1:0]   ecl_redirect_pc;
    logic               ecl_busy;

    cpu7_ecl_excp #(.GRLEN(GRLEN), .ECODE_W(ECODE_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .wb_valid           (wb_valid),
        .wb_pc              (wb_pc),
        .wb_excp            (wb_excp),
        .wb_ecode           (wb_ecode),
        .wb_ertn            (wb_ertn),
        .int_req            (int_req),
        .csr_crmd_ie        (csr_crmd_ie),
        .csr_eentry         (csr_eentry),
        .csr_era            (csr_era),
        .ifu_redirect_ready (ifu_redirect_ready),
        .ecl_commit_en      (ecl_commit_en),
        .ecl_csr_except     (ecl_csr_except),
        .ecl_csr_ertn       (ecl_csr_ertn),
        .ecl_csr_era        (ecl_csr_era),
        .ecl_csr_ecode      (ecl_csr_ecode),
        .ecl_flush          (ecl_flush),
        .ecl_redirect_valid (ecl_redirect_valid),
        .ecl_redirect_pc    (ecl_redirect_pc),
        .ecl_busy           (ecl_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit               m_active = 1'b0;
    int               m_age    = 0;
    int               m_kind   = K_INT;
    logic [GRLEN-1:0] m_era    = '0;
    logic [ECODE_W-1:0] m_ecode = '0;
    logic [GRLEN-1:0] m_rpc    = '0;
    int               m_txn    = 0;

    // All outputs in one vector: commit, except, ertn, flush, rvalid, busy,
    // era, ecode, redirect pc.
    wire [75:0] dut_v = {ecl_commit_en, ecl_csr_except, ecl_csr_ertn, ecl_flush,
                         ecl_redirect_valid, ecl_busy, ecl_csr_era, ecl_csr_ecode,
                         ecl_redirect_pc};

    function automatic logic [75:0] exp_v();
        logic flush_now;
        logic commit;
        flush_now = m_active && (m_age == 1);
        commit    = wb_valid && !m_active && !(int_req && csr_crmd_ie) && !wb_excp;
        return {commit, flush_now && (m_kind != K_ERTN), flush_now && (m_kind == K_ERTN),
                flush_now, m_active && (m_age >= 2), m_active, m_era, m_ecode, m_rpc};
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        if (reset) begin
            m_active = 1'b0;
            m_age    = 0;
            m_era    = '0;
            m_ecode  = '0;
            m_rpc    = '0;
        end else if (!m_active) begin
            if (wb_valid && ((int_req && csr_crmd_ie) || wb_excp || wb_ertn)) begin
                m_active = 1'b1;
                m_age    = 1;
                m_era    = wb_pc;
                if (int_req && csr_crmd_ie) begin
                    m_kind  = K_INT;
                    m_ecode = '0;
                end else if (wb_excp) begin
                    m_kind  = K_EXC;
                    m_ecode = wb_ecode;
                end else begin
                    m_kind  = K_ERTN;
                end
            end
        end else if (m_age == 1) begin
            m_rpc = (m_kind == K_ERTN) ? csr_era : csr_eentry;
            m_age = 2;
        end else if (ifu_redirect_ready) begin
            m_active = 1'b0;
            m_txn++;
            $display("txn %0d: kind=%0d era=%h ecode=%h target=%h redirect_cycles=%0d",
                     m_txn, m_kind, m_era, m_ecode, m_rpc, m_age - 1);
        end else begin
            m_age++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid = 1'b0;
        wb_pc    = '0;
        wb_excp  = 1'b0;
        wb_ecode = '0;
        wb_ertn  = 1'b0;
        int_req  = 1'b0;
    endtask

    task automatic test_reset();
        clear_wb();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_v !== 76'd0) begin
                n_bad++;
                $display("FAIL reset_state cyc%0d: got %h want %h", c, dut_v, 76'd0);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_exception();
        csr_eentry = 32'h1C000100;
        csr_crmd_ie = 1'b0;
        ifu_redirect_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            clear_wb();
            if (c == 0) begin
                wb_valid = 1'b1; wb_pc = 32'h1C000040; wb_excp = 1'b1; wb_ecode = 6'h0B;
            end
            @(negedge clk);
            n_cmp++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL exception cyc%0d: got %h want %h", c, dut_v, exp_v());
            end
            n_cmp++;
            case (c)
                0: if (ecl_commit_en !== 1'b0) begin
                       n_bad++; $display("FAIL exc_commit_en: got %b want 0", ecl_commit_en);
                   end
                1: if ({ecl_csr_except, ecl_flush, ecl_csr_era, ecl_csr_ecode} !== {2'b11, 32'h1C000040, 6'h0B}) begin
                       n_bad++; $display("FAIL exc_pulse: got %b%b %h %h want 11 1c000040 0b",
                                         ecl_csr_except, ecl_flush, ecl_csr_era, ecl_csr_ecode);
                   end
                2: if ({ecl_redirect_valid, ecl_redirect_pc} !== {1'b1, 32'h1C000100}) begin
                       n_bad++; $display("FAIL exc_redirect: got %b %h want 1 1c000100",
                                         ecl_redirect_valid, ecl_redirect_pc);
                   end
                default: if (ecl_busy !== 1'b0) begin
                       n_bad++; $display("FAIL exc_idle: got busy=%b want 0", ecl_busy);
                   end
            endcase
            tick();
        end
    endtask

    task automatic test_ertn();
        csr_era = 32'h1C000044;
        ifu_redirect_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            clear_wb();
            if (c == 0) begin
                wb_valid = 1'b1; wb_pc = 32'h1C000090; wb_ertn = 1'b1;
            end
            @(negedge clk);
            n_cmp++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL ertn cyc%0d: got %h want %h", c, dut_v, exp_v());
            end
            if (c == 0) begin
                n_cmp++;
                if (ecl_commit_en !== 1'b1) begin
                    n_bad++; $display("FAIL ertn_commit_en: got %b want 1", ecl_commit_en);
                end
            end else if (c == 1) begin
                n_cmp++;
                if ({ecl_csr_ertn, ecl_csr_except, ecl_flush} !== 3'b101) begin
                    n_bad++; $display("FAIL ertn_pulse: got %b%b%b want 101",
                                      ecl_csr_ertn, ecl_csr_except, ecl_flush);
                end
            end else if (c == 2) begin
                n_cmp++;
                if ({ecl_redirect_valid, ecl_redirect_pc} !== {1'b1, 32'h1C000044}) begin
                    n_bad++; $display("FAIL ertn_redirect: got %b %h want 1 1c000044",
                                      ecl_redirect_valid, ecl_redirect_pc);
                end
            end
            tick();
        end
    endtask

    task automatic test_priority();
        logic [5:0] want_ecode;
        ifu_redirect_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            csr_crmd_ie = (p == 0);
            want_ecode  = (p == 0) ? 6'h00 : 6'h0B;
            for (int c = 0; c < 4; c++) begin
                clear_wb();
                if (c == 0) begin
                    wb_valid = 1'b1; wb_pc = 32'h80; int_req = 1'b1;
                    wb_excp = 1'b1; wb_ecode = 6'h0B;
                end
                @(negedge clk);
                n_cmp++;
                if (dut_v !== exp_v()) begin
                    n_bad++;
                    $display("FAIL priority ie=%0d cyc%0d: got %h want %h", 1 - p, c, dut_v, exp_v());
                end
                if (c == 1) begin
                    n_cmp++;
                    if ({ecl_csr_except, ecl_csr_era, ecl_csr_ecode} !== {1'b1, 32'h80, want_ecode}) begin
                        n_bad++; $display("FAIL priority_ecode ie=%0d: got %b %h %h want 1 00000080 %h",
                                          1 - p, ecl_csr_except, ecl_csr_era, ecl_csr_ecode, want_ecode);
                    end
                end
                tick();
            end
        end
        csr_crmd_ie = 1'b0;
    endtask

    task automatic test_backpressure();
        csr_eentry = 32'h1C000200;
        for (int c = 0; c < 9; c++) begin
            clear_wb();
            ifu_redirect_ready = (c <= 1 || c == 7);
            if (c <= 7) begin
                wb_valid = 1'b1; wb_excp = 1'b1;
                wb_pc = (c == 0) ? 32'h300 : 32'h400 + c;
                wb_ecode = (c == 0) ? 6'h05 : 6'h11;
            end
            @(negedge clk);
            n_cmp++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL backpressure cyc%0d: got %h want %h", c, dut_v, exp_v());
            end
            if (c >= 2 && c <= 7) begin
                n_cmp++;
                if ({ecl_redirect_valid, ecl_busy, ecl_csr_except, ecl_flush, ecl_redirect_pc, ecl_csr_ecode}
                        !== {4'b1100, 32'h1C000200, 6'h05}) begin
                    n_bad++; $display("FAIL bp_hold cyc%0d: got %b%b%b%b %h %h want 1100 1c000200 05", c,
                                      ecl_redirect_valid, ecl_busy, ecl_csr_except, ecl_flush,
                                      ecl_redirect_pc, ecl_csr_ecode);
                end
            end else if (c == 8) begin
                n_cmp++;
                if (ecl_busy !== 1'b0) begin
                    n_bad++; $display("FAIL bp_release: got busy=%b want 0", ecl_busy);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        csr_eentry = 32'h1C000300;
        ifu_redirect_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            clear_wb();
            reset = (c == 3);
            if (c == 0) begin
                wb_valid = 1'b1; wb_pc = 32'h500; wb_excp = 1'b1; wb_ecode = 6'h07;
            end else if (c >= 4) begin
                wb_excp = 1'b1; int_req = 1'b1; csr_crmd_ie = 1'b1; wb_pc = 32'h600;
            end
            @(negedge clk);
            n_cmp++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL reset_mid cyc%0d: got %h want %h", c, dut_v, exp_v());
            end
            if (c >= 4) begin
                n_cmp++;
                if (dut_v !== 76'd0) begin
                    n_bad++; $display("FAIL reset_mid_quiet cyc%0d: got %h want 0", c, dut_v);
                end
            end
            tick();
        end
        reset = 1'b0;
        csr_crmd_ie = 1'b0;
    endtask

    task automatic test_eentry_change();
        for (int c = 0; c < 5; c++) begin
            clear_wb();
            csr_eentry = (c < 2) ? 32'h100 : 32'h200;
            ifu_redirect_ready = (c == 3);
            if (c == 0) begin
                wb_valid = 1'b1; wb_pc = 32'h700; wb_excp = 1'b1; wb_ecode = 6'h02;
            end
            @(negedge clk);
            n_cmp++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL eentry_change cyc%0d: got %h want %h", c, dut_v, exp_v());
            end
            if (c == 2 || c == 3) begin
                n_cmp++;
                if ({ecl_redirect_valid, ecl_redirect_pc} !== {1'b1, 32'h100}) begin
                    n_bad++; $display("FAIL eentry_sample cyc%0d: got %b %h want 1 00000100",
                                      c, ecl_redirect_valid, ecl_redirect_pc);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        csr_eentry = 32'h1C000800;
        csr_era = 32'h1C000900;
        ifu_redirect_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            clear_wb();
            if (c == 0) begin
                wb_valid = 1'b1; wb_pc = 32'hA0; wb_ertn = 1'b1;
            end else if (c <= 2) begin
                wb_valid = 1'b1; wb_pc = 32'hB0; wb_excp = 1'b1; wb_ecode = 6'h3F;
            end else if (c == 3) begin
                wb_valid = 1'b1; wb_pc = 32'hC0; wb_excp = 1'b1; wb_ecode = 6'h21;
            end
            @(negedge clk);
            n_cmp++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", c, dut_v, exp_v());
            end
            if (c == 4) begin
                n_cmp++;
                if ({ecl_csr_except, ecl_csr_era, ecl_csr_ecode} !== {1'b1, 32'hC0, 6'h21}) begin
                    n_bad++; $display("FAIL b2b_second: got %b %h %h want 1 000000c0 21",
                                      ecl_csr_except, ecl_csr_era, ecl_csr_ecode);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            reset       = ($urandom_range(0, 49) == 0);
            wb_valid    = $urandom_range(0, 1);
            wb_pc       = $urandom;
            wb_excp     = ($urandom_range(0, 3) == 0);
            wb_ecode    = 6'($urandom);
            wb_ertn     = ($urandom_range(0, 3) == 0);
            int_req     = ($urandom_range(0, 3) == 0);
            csr_crmd_ie = $urandom_range(0, 1);
            csr_eentry  = $urandom;
            csr_era     = $urandom;
            ifu_redirect_ready = $urandom_range(0, 1);
            @(negedge clk);
            n_cmp++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL random cyc%0d: got %h want %h", c, dut_v, exp_v());
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        clear_wb();
        reset = 1'b1;
        csr_crmd_ie = 1'b0;
        csr_eentry = '0;
        csr_era = '0;
        ifu_redirect_ready = 1'b0;
        tick();
        test_reset();
        test_exception();
        test_ertn();
        test_priority();
        test_backpressure();
        test_reset_mid();
        test_eentry_change();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
